// File: rtl/io_frame_bridge.sv
// -----------------------------------------------------------------------------
// io_frame_bridge
//
// Once per sample-rate tick, this block moves one frame of samples between the
// DSP core's io memory and the converter streams:
//   1. It reads NUM_CHANNELS output samples from io memory, starting at
//      OUT_BASE, and presents each one on the outbound (DAC) stream.
//   2. It accepts NUM_CHANNELS samples from the inbound (ADC) stream and writes
//      them into io memory, starting at IN_BASE.
// Channels are handled in ascending order in both directions. When nothing
// stalls the streams, a frame takes 4*NUM_CHANNELS+1 cycles.
//
// Ports
//   clk, reset_n               clock; asynchronous active-low reset
//   frame_start                single-cycle sample-rate tick
//   io_rd_addr/_en/_data       io memory read port (data returns 1 cycle later)
//   io_wr_addr/_en/_data       io memory write port
//   out_valid/_ready/_data,
//   out_channel                outbound stream (valid/ready handshake)
//   in_valid/_ready/_data      inbound stream (valid/ready handshake)
//   busy                       frame in progress (any state except IDLE)
//   done                       one-cycle pulse on the last cycle of a frame
//   overrun_count              ticks that arrived while busy (saturates at 255)
// -----------------------------------------------------------------------------
module io_frame_bridge #(
  parameter int                       IO_WIDTH      = 24,
  parameter int                       IO_ADDR_WIDTH = 10,
  parameter int                       NUM_CHANNELS  = 8,
  parameter logic [IO_ADDR_WIDTH-1:0] OUT_BASE      = IO_ADDR_WIDTH'(10'h040),
  parameter logic [IO_ADDR_WIDTH-1:0] IN_BASE       = IO_ADDR_WIDTH'(10'h000)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  // io memory
  output logic [IO_ADDR_WIDTH-1:0] io_rd_addr,
  output logic                     io_rd_en,
  input  logic [IO_WIDTH-1:0]      io_rd_data,
  output logic [IO_ADDR_WIDTH-1:0] io_wr_addr,
  output logic                     io_wr_en,
  output logic [IO_WIDTH-1:0]      io_wr_data,
  // outbound (DAC) stream
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IO_WIDTH-1:0]      out_data,
  output logic [7:0]               out_channel,
  // inbound (ADC) stream
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IO_WIDTH-1:0]      in_data,
  // status
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               overrun_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    TX,
    RX,
    DONE
  } state_t;

  // An 8-bit channel index covers the full 1..256 channel range.
  localparam logic [7:0] LAST_CH = 8'(NUM_CHANNELS - 1);

  state_t              state_q, state_d;
  logic [7:0]          ch_q, ch_d;
  logic [IO_WIDTH-1:0] out_data_q;
  logic [7:0]          overrun_q;

  // ---------------------------------------------------------------------------
  // State, channel counter, sample holding register and overrun counter
  // ---------------------------------------------------------------------------
  // NOTE: asynchronous reset sits in the sensitivity list, and every register
  // here is updated with non-blocking assignments so all of them see the
  // pre-edge values of each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      out_data_q <= '0;
      overrun_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;

      // io_rd_data answers the RD_REQ of the previous cycle.
      if (state_q == RD_WAIT) begin
        out_data_q <= io_rd_data;
      end

      // A tick is an overrun in any non-IDLE state, DONE included.
      if (frame_start && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and per-state strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    io_rd_en  = 1'b0;
    io_wr_en  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = RD_REQ;
          ch_d    = '0;
        end
      end

      RD_REQ: begin
        io_rd_en = 1'b1;
        state_d  = RD_WAIT;
      end

      RD_WAIT: begin
        state_d = TX;
      end

      TX: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = RX;
            ch_d    = '0;
          end else begin
            state_d = RD_REQ;
            ch_d    = ch_q + 8'd1;
          end
        end
      end

      RX: begin
        in_ready = 1'b1;
        if (in_valid) begin
          io_wr_en = 1'b1;
          if (ch_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            ch_d = ch_q + 8'd1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath outputs. Addresses wrap modulo the io address width. They are
  // driven continuously and qualified by the enables.
  // ---------------------------------------------------------------------------
  assign io_rd_addr    = OUT_BASE + IO_ADDR_WIDTH'(ch_q);
  assign io_wr_addr    = IN_BASE + IO_ADDR_WIDTH'(ch_q);
  assign io_wr_data    = in_data;
  assign out_data      = out_data_q;
  assign out_channel   = ch_q;
  assign busy          = (state_q != IDLE);
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_io_frame_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_frame_bridge
//
// Directed bench for io_frame_bridge. dut drives a 4-channel frame against a
// small io memory model. dut1 is a 1-channel instance for the minimum-size
// frame. The first frame is checked cycle by cycle from a vector table. The
// multi-cycle corner cases are written out as hand sequences: output stall,
// toggling input valid, overruns and saturation, and reset in the middle of a
// frame.
// -----------------------------------------------------------------------------
module tb_io_frame_bridge;

  localparam int AW = 10;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;

  // 4-channel instance
  logic          frame_start;
  logic [AW-1:0] io_rd_addr, io_wr_addr;
  logic          io_rd_en, io_wr_en;
  logic [DW-1:0] io_rd_data, io_wr_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_channel;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          busy, done;
  logic [7:0]    overrun_count;

  // 1-channel instance
  logic          frame_start1;
  logic [AW-1:0] io_rd_addr1, io_wr_addr1;
  logic          io_rd_en1, io_wr_en1;
  logic [DW-1:0] io_rd_data1, io_wr_data1;
  logic          out_valid1, out_ready1;
  logic [DW-1:0] out_data1;
  logic [7:0]    out_channel1;
  logic          in_valid1, in_ready1;
  logic [DW-1:0] in_data1;
  logic          busy1, done1;
  logic [7:0]    overrun_count1;

  always #5 clk = ~clk;

  io_frame_bridge #(
    .IO_WIDTH(DW), .IO_ADDR_WIDTH(AW), .NUM_CHANNELS(4),
    .OUT_BASE(10'h040), .IN_BASE(10'h000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .io_rd_addr(io_rd_addr), .io_rd_en(io_rd_en), .io_rd_data(io_rd_data),
    .io_wr_addr(io_wr_addr), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .overrun_count(overrun_count)
  );

  io_frame_bridge #(
    .IO_WIDTH(DW), .IO_ADDR_WIDTH(AW), .NUM_CHANNELS(1),
    .OUT_BASE(10'h040), .IN_BASE(10'h000)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start1),
    .io_rd_addr(io_rd_addr1), .io_rd_en(io_rd_en1), .io_rd_data(io_rd_data1),
    .io_wr_addr(io_wr_addr1), .io_wr_en(io_wr_en1), .io_wr_data(io_wr_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_channel(out_channel1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .busy(busy1), .done(done1), .overrun_count(overrun_count1)
  );

  // ---------------------------------------------------------------------------
  // io memory model: read data one cycle after the enable (junk otherwise),
  // writes logged in order.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] ra1_q[$];
  logic [AW-1:0] wa1_q[$];
  logic [DW-1:0] wd1_q[$];

  always @(posedge clk) begin
    io_rd_data  <= io_rd_en  ? mem[io_rd_addr]  : 24'hEEEEEE;
    io_rd_data1 <= io_rd_en1 ? mem[io_rd_addr1] : 24'hEEEEEE;
    if (io_wr_en) begin
      wa_q.push_back(io_wr_addr);
      wd_q.push_back(io_wr_data);
    end
    if (io_rd_en1) ra1_q.push_back(io_rd_addr1);
    if (io_wr_en1) begin
      wa1_q.push_back(io_wr_addr1);
      wd1_q.push_back(io_wr_data1);
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the first frame (one record per cycle)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          fs, ordy, ivld;
    logic [DW-1:0] idata;
    logic          busy, done, ovld, irdy, rden, wren;
    logic [7:0]    och;
    logic [DW-1:0] odata;
    logic [AW-1:0] rdaddr, wraddr;
    logic [DW-1:0] wrdata;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  function automatic vec_t base_vec(input logic b);
    vec_t v;
    v = '{default: '0};
    v.ordy  = 1'b1;
    v.ivld  = 1'b1;
    v.idata = 24'h5A5A5A;
    v.busy  = b;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Run one frame on dut, starting with a tick. Optional output stall on one
  // channel, toggling in_valid, and extra ticks on even cycles 2..2*n while
  // busy. len is the cycle on which done was seen (cycle 1 = first non-IDLE).
  // ---------------------------------------------------------------------------
  task automatic run_frame(input int stall_ch, input int stall_n,
                           input logic [DW-1:0] stall_data, input bit toggle,
                           input int ovr_pulses, output int len);
    int stall_left;
    int cyc;
    stall_left = stall_n;
    len = -1;
    @(negedge clk);
    frame_start = 1'b1;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < 300) begin
      frame_start = (cyc >= 2 && cyc % 2 == 0 && cyc <= 2 * ovr_pulses);
      in_valid    = toggle ? (cyc % 2 == 1) : 1'b1;
      in_data     = 24'hB00000 + 24'(cyc);
      out_ready   = 1'b1;
      #1;
      if (stall_left > 0 &&
          (stall_left < stall_n || (out_valid && int'(out_channel) == stall_ch))) begin
        check("stall_valid", cyc, out_valid, 1);
        check("stall_channel", cyc, out_channel, stall_ch);
        check("stall_data", cyc, out_data, stall_data);
        out_ready = 1'b0;
        stall_left--;
      end
      if (in_ready && !in_valid) check("no_write_when_invalid", cyc, io_wr_en, 0);
      if (done) begin
        len = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    frame_start = 1'b0;
    if (len < 0) check("frame_done_timeout", cyc, done, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int len;
    int guard;

    for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
    mem[10'h040] = 24'h100001;
    mem[10'h041] = 24'h200002;
    mem[10'h042] = 24'h300003;
    mem[10'h043] = 24'h400004;

    // Table: IDLE with tick, 4 x {RD_REQ, RD_WAIT, TX}, 4 x RX, DONE, IDLE.
    tbl[0] = base_vec(1'b0);
    tbl[0].fs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tbl[1 + 3*k]        = base_vec(1'b1);
      tbl[1 + 3*k].rden   = 1'b1;
      tbl[1 + 3*k].rdaddr = 10'h040 + 10'(k);
      tbl[2 + 3*k]        = base_vec(1'b1);
      tbl[3 + 3*k]        = base_vec(1'b1);
      tbl[3 + 3*k].ovld   = 1'b1;
      tbl[3 + 3*k].och    = 8'(k);
      tbl[3 + 3*k].odata  = 24'(k + 1) * 24'h100001;
      tbl[13 + k]         = base_vec(1'b1);
      tbl[13 + k].idata   = 24'hA00000 + 24'(k);
      tbl[13 + k].irdy    = 1'b1;
      tbl[13 + k].wren    = 1'b1;
      tbl[13 + k].wraddr  = 10'(k);
      tbl[13 + k].wrdata  = 24'hA00000 + 24'(k);
    end
    tbl[17]      = base_vec(1'b1);
    tbl[17].done = 1'b1;
    tbl[18]      = base_vec(1'b0);

    // Reset state
    reset_n      = 1'b0;
    frame_start  = 1'b0;
    out_ready    = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    frame_start1 = 1'b0;
    out_ready1   = 1'b1;
    in_valid1    = 1'b1;
    in_data1     = 24'hC0FFEE;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 0, busy, 0);
    check("rst_done", 0, done, 0);
    check("rst_out_valid", 0, out_valid, 0);
    check("rst_in_ready", 0, in_ready, 0);
    check("rst_rd_en", 0, io_rd_en, 0);
    check("rst_wr_en", 0, io_wr_en, 0);
    check("rst_overrun", 0, overrun_count, 0);
    check("rst_out_data", 0, out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // First frame from the table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      frame_start = tbl[i].fs;
      out_ready   = tbl[i].ordy;
      in_valid    = tbl[i].ivld;
      in_data     = tbl[i].idata;
      #1;
      check("busy", i, busy, tbl[i].busy);
      check("done", i, done, tbl[i].done);
      check("out_valid", i, out_valid, tbl[i].ovld);
      check("in_ready", i, in_ready, tbl[i].irdy);
      check("io_rd_en", i, io_rd_en, tbl[i].rden);
      check("io_wr_en", i, io_wr_en, tbl[i].wren);
      if (tbl[i].rden) check("io_rd_addr", i, io_rd_addr, tbl[i].rdaddr);
      if (tbl[i].ovld) begin
        check("out_channel", i, out_channel, tbl[i].och);
        check("out_data", i, out_data, tbl[i].odata);
      end
      if (tbl[i].wren) begin
        check("io_wr_addr", i, io_wr_addr, tbl[i].wraddr);
        check("io_wr_data", i, io_wr_data, tbl[i].wrdata);
      end
    end
    frame_start = 1'b0;
    check("frame1_writes", 0, wa_q.size(), 4);
    check("frame1_overrun", 0, overrun_count, 0);

    // Output stall: 10 cycles on channel 2 lengthen the frame to 27 cycles
    wa_q.delete();
    wd_q.delete();
    run_frame(2, 10, 24'h300003, 1'b0, 0, len);
    check("stall_len", 0, len, 27);
    check("stall_writes", 0, wa_q.size(), 4);
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      check("stall_wr_addr", k, wa_q[k], k);
      check("stall_wr_data", k, wd_q[k], 24'hB00017 + 24'(k));
    end

    // in_valid toggling in RX: writes on odd cycles 13,15,17,19; DONE at 20
    wa_q.delete();
    wd_q.delete();
    run_frame(-1, 0, 24'h0, 1'b1, 0, len);
    check("toggle_len", 0, len, 20);
    check("toggle_writes", 0, wa_q.size(), 4);
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      check("toggle_wr_addr", k, wa_q[k], k);
      check("toggle_wr_data", k, wd_q[k], 24'hB0000D + 24'(2 * k));
    end

    // Three ticks while busy: counted, frame unaffected
    wa_q.delete();
    wd_q.delete();
    run_frame(-1, 0, 24'h0, 1'b0, 3, len);
    check("ovr_len", 0, len, 17);
    check("ovr_count3", 0, overrun_count, 3);
    check("ovr_writes", 0, wa_q.size(), 4);
    // A tick during DONE is an overrun and does not start a frame
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("done_tick_busy", 0, busy, 0);
    check("done_tick_overrun", 0, overrun_count, 4);
    repeat (3) @(negedge clk);
    #1;
    check("done_tick_idle", 0, busy, 0);

    // Saturation: frame parked in TX ch0, 300 ticks while busy
    @(negedge clk);
    out_ready   = 1'b0;
    frame_start = 1'b1;
    repeat (301) @(negedge clk);
    #1;
    check("sat_overrun", 0, overrun_count, 255);
    check("sat_out_valid", 0, out_valid, 1);
    check("sat_channel", 0, out_channel, 0);
    frame_start = 1'b0;
    reset_n     = 1'b0;
    #1;
    check("sat_rst_overrun", 0, overrun_count, 0);
    check("sat_rst_busy", 0, busy, 0);
    out_ready = 1'b1;

    // Tick is honoured on the first edge after reset release
    @(negedge clk);
    reset_n     = 1'b1;
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_data     = 24'hD00000;
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("post_rst_busy", 0, busy, 1);
    check("post_rst_rd_en", 0, io_rd_en, 1);
    check("post_rst_rd_addr", 0, io_rd_addr, 10'h040);

    // Reset in RX after the ch1 write
    guard = 0;
    while (wa_q.size() < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_rst_reach_rx", 0, wa_q.size(), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 0, busy, 0);
    check("mid_rst_done", 0, done, 0);
    check("mid_rst_out_valid", 0, out_valid, 0);
    check("mid_rst_in_ready", 0, in_ready, 0);
    check("mid_rst_rd_en", 0, io_rd_en, 0);
    check("mid_rst_wr_en", 0, io_wr_en, 0);
    check("mid_rst_out_data", 0, out_data, 0);
    check("mid_rst_overrun", 0, overrun_count, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_no_writes", 0, wa_q.size(), 2);
    check("mid_rst_idle", 0, busy, 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("restart_rd_en", 0, io_rd_en, 1);
    check("restart_rd_addr", 0, io_rd_addr, 10'h040);
    check("restart_channel", 0, out_channel, 0);
    len = -1;
    for (int c = 1; c < 100; c++) begin
      if (done) begin
        len = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("restart_len", 0, len, 17);
    check("restart_writes", 0, wa_q.size(), 6);
    for (int k = 0; k < 4 && k + 2 < wa_q.size(); k++) begin
      check("restart_wr_addr", k, wa_q[k + 2], k);
    end

    // Single-channel instance: one read, one write, done on cycle 5
    @(negedge clk);
    frame_start1 = 1'b1;
    @(negedge clk);
    frame_start1 = 1'b0;
    #1;
    len = -1;
    for (int c = 1; c < 50; c++) begin
      if (out_valid1) begin
        check("nc1_out_data", c, out_data1, 24'h100001);
        check("nc1_out_channel", c, out_channel1, 0);
      end
      if (in_ready1) check("nc1_wr_en", c, io_wr_en1, 1);
      if (done1) begin
        len = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("nc1_len", 0, len, 5);
    check("nc1_reads", 0, ra1_q.size(), 1);
    if (ra1_q.size() > 0) check("nc1_rd_addr", 0, ra1_q[0], 10'h040);
    check("nc1_writes", 0, wa1_q.size(), 1);
    if (wa1_q.size() > 0) begin
      check("nc1_wr_addr", 0, wa1_q[0], 10'h000);
      check("nc1_wr_data", 0, wd1_q[0], 24'hC0FFEE);
    end
    @(negedge clk);
    #1;
    check("nc1_idle", 0, busy1, 0);
    check("nc1_overrun", 0, overrun_count1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/io_frame_bridge.md
IO_FRAME_BRIDGE -- requirements
Module: io_frame_bridge

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 24: io memory / stream sample width.
REQ-002 SHALL have parameter IO_ADDR_WIDTH, default 10: io memory address width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 8: samples per direction per frame; range 1..256.
REQ-004 SHALL have parameter OUT_BASE, default 10'h040: io address of output channel 0 (the region the DSP core writes with OUT).
REQ-005 SHALL have parameter IN_BASE, default 10'h000: io address of input channel 0 (the region the DSP core reads with IN).
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port frame_start, input, 1: single-cycle sample-rate tick.
REQ-009 SHALL have port io_rd_addr, output, IO_ADDR_WIDTH: io memory read address.
REQ-010 SHALL have port io_rd_en, output, 1: io memory read enable.
REQ-011 SHALL have port io_rd_data, input, IO_WIDTH: read data, valid exactly one cycle after io_rd_en.
REQ-012 SHALL have port io_wr_addr, output, IO_ADDR_WIDTH: io memory write address.
REQ-013 SHALL have port io_wr_en, output, 1: io memory write enable.
REQ-014 SHALL have port io_wr_data, output, IO_WIDTH: io memory write data.
REQ-015 SHALL have ports out_valid output 1, out_ready input 1, out_data output IO_WIDTH, out_channel output 8: outbound (DAC) stream.
REQ-016 SHALL have ports in_valid input 1, in_ready output 1, in_data input IO_WIDTH: inbound (ADC) stream.
REQ-017 SHALL have ports busy output 1, done output 1, overrun_count output 8: status.

Function
REQ-018 SHALL implement states IDLE, RD_REQ, RD_WAIT, TX, RX, DONE, plus channel counter ch.
REQ-019 IDLE: frame_start=1 -> RD_REQ with ch=0; otherwise stay.
REQ-020 RD_REQ: io_rd_en=1, io_rd_addr=OUT_BASE+ch (mod 2^IO_ADDR_WIDTH); next RD_WAIT.
REQ-021 RD_WAIT: capture io_rd_data into out_data register at end of cycle; next TX.
REQ-022 TX: out_valid=1, out_channel=ch, out_data stable; on out_valid&&out_ready: if ch==NUM_CHANNELS-1 -> RX with ch=0, else RD_REQ with ch+1.
REQ-023 TX SHALL hold out_data/out_channel unchanged while out_ready=0, indefinitely.
REQ-024 RX: in_ready=1; on in_valid&&in_ready same cycle: io_wr_en=1, io_wr_addr=IN_BASE+ch, io_wr_data=in_data (combinational); if ch==NUM_CHANNELS-1 -> DONE, else ch+1.
REQ-025 DONE: done=1 for exactly one cycle; next IDLE.
REQ-026 io_rd_en, io_wr_en, out_valid, in_ready SHALL be 0 in every state not named above for them.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 frame_start=1 while not IDLE SHALL be ignored for sequencing and SHALL increment overrun_count, saturating at 255.
REQ-029 frame_start=1 in DONE SHALL count as overrun (not start a frame).
REQ-030 Unstalled frame SHALL take exactly 4*NUM_CHANNELS+1 cycles from first non-IDLE cycle to last (DONE) cycle.
REQ-031 Channel order SHALL be ascending 0..NUM_CHANNELS-1 in both directions; no address wrap within ch other than modulo io address width.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE, ch=0, out_data=0, overrun_count=0; hence out_valid=0, in_ready=0, io_rd_en=0, io_wr_en=0, busy=0, done=0.
REQ-033 Reset mid-frame SHALL abandon the frame; no further io writes occur until a new frame_start after release.
REQ-034 First frame_start SHALL be honoured on the first rising edge after reset_n deassertion.

Verification (NUM_CHANNELS=4, OUT_BASE=0x040, IN_BASE=0x000)
REQ-035 Memory preload 0x040..0x043={0x100001,0x200002,0x300003,0x400004}, out_ready=1, in_valid=1 in_data=0xA00000+k -> out stream 0x100001..0x400004 ch 0..3, writes 0x000..0x003=0xA00000..0xA00003, done at cycle 17 after frame_start edge.
REQ-036 out_ready=0 for 10 cycles during ch=2 TX -> out_data=0x300003 held stable, out_valid high throughout, frame length +10.
REQ-037 in_valid toggling 1/0 each cycle in RX -> exactly 4 writes, addresses 0x000..0x003 in order, no write on in_valid=0 cycles.
REQ-038 frame_start pulsed 3 times while busy -> overrun_count=3, single frame executed; 300 overruns -> overrun_count=255.
REQ-039 reset_n low during RX after ch=1 write -> all outputs reset values immediately; next frame starts at ch=0 RD_REQ address 0x040.
REQ-040 NUM_CHANNELS=1 -> one read of 0x040, one write to 0x000, done 5 cycles after frame_start edge.
